// File: rtl/mips_axi_lite_host_master_pkg.sv
// Shared definitions for the host-side AXI4-Lite master that feeds the MIPS CPU MMIO port:
// bus widths, AXI response codes and the master FSM state encoding.
package mips_axi_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WR_B = 3'd2,
    ST_RD_A = 3'd3,
    ST_RD_R = 3'd4,
    ST_RSP  = 3'd5
  } state_t;

  // Only word-aligned accesses are forwarded to the CPU slave port.
  function automatic logic misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mips_axi_lite_host_master_if.sv
// Command/response port plus AXI4-Lite master channels for the host master.
// Every channel transfers on a clock edge where valid & ready are both high; a raised valid
// keeps its payload stable until that edge and ready never waits on anything but valid.
interface mips_axi_lite_host_master_if #(
  parameter int ADDR_W = mips_axi_pkg::ADDR_W,
  parameter int DATA_W = mips_axi_pkg::DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [3:0]        cmd_wstrb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;

  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  m_axi_arready, m_axi_awready, m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    output m_axi_araddr, m_axi_arvalid, m_axi_awaddr, m_axi_awvalid,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready, m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output m_axi_arready, m_axi_awready, m_axi_wready,
    output m_axi_bresp, m_axi_bvalid, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    input  m_axi_araddr, m_axi_arvalid, m_axi_awaddr, m_axi_awvalid,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready, m_axi_rready
  );

endinterface

// File: rtl/mips_axi_lite_host_master.sv
// Single-outstanding AXI4-Lite initiator: turns one host command into one AXI read or write
// on the CPU MMIO port and returns the AXI response code and read data.
module mips_axi_lite_host_master
  import mips_axi_pkg::*;
(
  input  logic                        mips_cpu_clk,
  input  logic                        mips_cpu_reset,
  mips_axi_lite_host_master_if.master bus,
  output state_t                      dbg_state
);

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;

  assign aw_hs     = bus.m_axi_awvalid & bus.m_axi_awready;
  assign w_hs      = bus.m_axi_wvalid & bus.m_axi_wready;
  assign dbg_state = state;

  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset) begin
    if (!mips_cpu_reset) begin
      state             <= ST_IDLE;
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      bus.cmd_ready     <= 1'b0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_write     <= 1'b0;
      bus.rsp_rdata     <= '0;
      bus.rsp_resp      <= RESP_OKAY;
      bus.m_axi_araddr  <= '0;
      bus.m_axi_arvalid <= 1'b0;
      bus.m_axi_awaddr  <= '0;
      bus.m_axi_awvalid <= 1'b0;
      bus.m_axi_wdata   <= '0;
      bus.m_axi_wstrb   <= '0;
      bus.m_axi_wvalid  <= 1'b0;
      bus.m_axi_bready  <= 1'b0;
      bus.m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            if (misaligned(bus.cmd_addr[1:0])) begin
              // Rejected locally; the CPU port never sees the access.
              bus.rsp_write <= bus.cmd_write;
              bus.rsp_rdata <= '0;
              bus.rsp_resp  <= RESP_SLVERR;
              bus.rsp_valid <= 1'b1;
              state         <= ST_RSP;
            end else if (bus.cmd_write) begin
              bus.m_axi_awaddr  <= bus.cmd_addr;
              bus.m_axi_wdata   <= bus.cmd_wdata;
              bus.m_axi_wstrb   <= bus.cmd_wstrb;
              bus.m_axi_awvalid <= 1'b1;
              bus.m_axi_wvalid  <= 1'b1;
              aw_done           <= 1'b0;
              w_done            <= 1'b0;
              state             <= ST_WR;
            end else begin
              bus.m_axi_araddr  <= bus.cmd_addr;
              bus.m_axi_arvalid <= 1'b1;
              state             <= ST_RD_A;
            end
          end
        end

        ST_WR: begin
          // AW and W complete independently; leave once both have been accepted.
          if (aw_hs) begin
            bus.m_axi_awvalid <= 1'b0;
            aw_done           <= 1'b1;
          end
          if (w_hs) begin
            bus.m_axi_wvalid <= 1'b0;
            w_done           <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bus.m_axi_bready <= 1'b1;
            state            <= ST_WR_B;
          end
        end

        ST_WR_B: begin
          if (bus.m_axi_bvalid) begin
            bus.m_axi_bready <= 1'b0;
            bus.rsp_write    <= 1'b1;
            bus.rsp_rdata    <= '0;
            bus.rsp_resp     <= bus.m_axi_bresp;
            bus.rsp_valid    <= 1'b1;
            state            <= ST_RSP;
          end
        end

        ST_RD_A: begin
          if (bus.m_axi_arready) begin
            bus.m_axi_arvalid <= 1'b0;
            bus.m_axi_rready  <= 1'b1;
            state             <= ST_RD_R;
          end
        end

        ST_RD_R: begin
          if (bus.m_axi_rvalid) begin
            bus.m_axi_rready <= 1'b0;
            bus.rsp_write    <= 1'b0;
            bus.rsp_rdata    <= bus.m_axi_rdata;
            bus.rsp_resp     <= bus.m_axi_rresp;
            bus.rsp_valid    <= 1'b1;
            state            <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_axi_lite_host_master.sv
// Bench for mips_axi_lite_host_master: randomized commands against a word-memory reference
// model, an AXI slave with programmable delays, and a scoreboard on the response port.
module tb_mips_axi_lite_host_master;
  import mips_axi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_axi_lite_host_master_if bus ();
  state_t dbg_state;

  mips_axi_lite_host_master dut (
    .mips_cpu_clk  (clk),
    .mips_cpu_reset(rst_n),
    .bus           (bus),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [34:0] exp_q[$];        // {write, resp, rdata}
  int          exp_lat_q[$];    // 0 = latency not checked
  logic [13:0] exp_aw_q[$];
  logic [35:0] exp_w_q[$];      // {strb, data}
  logic [13:0] exp_ar_q[$];
  int          n_b_exp = 0;
  int          n_b_seen = 0;
  int          acc_cyc = 0;
  logic        axi_valid_seen = 1'b0;

  logic [31:0] ref_mem[int];
  logic [31:0] sl_mem[int];

  // slave / consumer configuration
  int         aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0, b_lat = 0, rsp_hold = 0;
  logic [1:0] sl_resp = 2'b00;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] default_word(input int w);
    return {16'hC0DE, 16'(w)};
  endfunction

  function automatic logic [31:0] ref_read(input logic [13:0] a);
    int w = int'(a >> 2);
    return ref_mem.exists(w) ? ref_mem[w] : default_word(w);
  endfunction

  function automatic void ref_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v = ref_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a >> 2)] = v;
  endfunction

  function automatic logic [31:0] sl_read(input logic [13:0] a);
    int w = int'(a >> 2);
    return sl_mem.exists(w) ? sl_mem[w] : default_word(w);
  endfunction

  function automatic void sl_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    sl_mem[int'(a >> 2)] = (sl_read(a) & ~mask) | (d & mask);
  endfunction

  // ---------------- AXI slave model ----------------
  logic        s_aw_hs, s_w_hs, s_ar_hs, s_b_hs, s_r_hs;
  logic        p_awv, p_wv, p_arv, p_aw_hs, p_w_hs, p_ar_hs;
  logic [13:0] p_awaddr, p_araddr, s_awaddr, s_araddr;
  logic [35:0] p_w, s_w;
  logic        aw_got, w_got, b_pend, r_pend;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;

  task automatic slave_clear();
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_arready = 1'b0;
    bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
    bus.m_axi_rvalid = 1'b0; bus.m_axi_rresp = 2'b00; bus.m_axi_rdata = '0;
    {s_aw_hs, s_w_hs, s_ar_hs, s_b_hs, s_r_hs} = '0;
    {p_awv, p_wv, p_arv, p_aw_hs, p_w_hs, p_ar_hs} = '0;
    {aw_got, w_got, b_pend, r_pend} = '0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
  endtask

  initial begin : slave_proc
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {s_aw_hs, s_w_hs, s_ar_hs, s_b_hs, s_r_hs} = '0;
        {p_awv, p_wv, p_arv, p_aw_hs, p_w_hs, p_ar_hs} = '0;
      end else begin
        s_aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
        s_w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
        s_ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
        s_b_hs  = bus.m_axi_bvalid && bus.m_axi_bready;
        s_r_hs  = bus.m_axi_rvalid && bus.m_axi_rready;
        if (p_aw_hs) check("awvalid_drop", 64'(bus.m_axi_awvalid), 64'd0);
        if (p_w_hs)  check("wvalid_drop", 64'(bus.m_axi_wvalid), 64'd0);
        if (p_ar_hs) check("arvalid_drop", 64'(bus.m_axi_arvalid), 64'd0);
        if (p_awv && !p_aw_hs)
          check("aw_stable", 64'({bus.m_axi_awvalid, bus.m_axi_awaddr}), 64'({1'b1, p_awaddr}));
        if (p_wv && !p_w_hs)
          check("w_stable", 64'({bus.m_axi_wvalid, bus.m_axi_wstrb, bus.m_axi_wdata}), 64'({1'b1, p_w}));
        if (p_arv && !p_ar_hs)
          check("ar_stable", 64'({bus.m_axi_arvalid, bus.m_axi_araddr}), 64'({1'b1, p_araddr}));
        if (bus.m_axi_awvalid || bus.m_axi_wvalid || bus.m_axi_arvalid) axi_valid_seen = 1'b1;
        if (s_aw_hs) begin
          s_awaddr = bus.m_axi_awaddr;
          if (exp_aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
          else check("aw_addr", 64'(bus.m_axi_awaddr), 64'(exp_aw_q.pop_front()));
        end
        if (s_w_hs) begin
          s_w = {bus.m_axi_wstrb, bus.m_axi_wdata};
          if (exp_w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
          else check("w_strb_data", 64'(s_w), 64'(exp_w_q.pop_front()));
        end
        if (s_ar_hs) begin
          s_araddr = bus.m_axi_araddr;
          if (exp_ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
          else check("ar_addr", 64'(bus.m_axi_araddr), 64'(exp_ar_q.pop_front()));
        end
        if (s_b_hs) n_b_seen++;
        aw_cnt = (bus.m_axi_awvalid && !s_aw_hs) ? aw_cnt + 1 : 0;
        w_cnt  = (bus.m_axi_wvalid && !s_w_hs) ? w_cnt + 1 : 0;
        ar_cnt = (bus.m_axi_arvalid && !s_ar_hs) ? ar_cnt + 1 : 0;
        p_awv = bus.m_axi_awvalid; p_awaddr = bus.m_axi_awaddr; p_aw_hs = s_aw_hs;
        p_wv  = bus.m_axi_wvalid;  p_w = {bus.m_axi_wstrb, bus.m_axi_wdata}; p_w_hs = s_w_hs;
        p_arv = bus.m_axi_arvalid; p_araddr = bus.m_axi_araddr; p_ar_hs = s_ar_hs;
      end
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (s_b_hs) bus.m_axi_bvalid = 1'b0;
        if (s_r_hs) bus.m_axi_rvalid = 1'b0;
        if (s_aw_hs) aw_got = 1'b1;
        if (s_w_hs) w_got = 1'b1;
        if (aw_got && w_got) begin
          sl_write(s_awaddr, s_w[31:0], s_w[35:32]);
          aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = 0;
        end
        if (b_pend) begin
          if (b_cnt >= b_lat) begin
            bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = sl_resp; b_pend = 1'b0;
          end else b_cnt++;
        end
        if (s_ar_hs) begin r_pend = 1'b1; r_cnt = 0; end
        if (r_pend) begin
          if (r_cnt >= r_lat) begin
            bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = sl_read(s_araddr);
            bus.m_axi_rresp = sl_resp; r_pend = 1'b0;
          end else r_cnt++;
        end
        bus.m_axi_awready = bus.m_axi_awvalid && (aw_cnt >= aw_lat);
        bus.m_axi_wready  = bus.m_axi_wvalid && (w_cnt >= w_lat);
        bus.m_axi_arready = bus.m_axi_arvalid && (ar_cnt >= ar_lat);
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  int          hold_cnt = 0;
  logic        rsp_seen = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
  int          first_cyc = 0;
  logic [34:0] prev_rsp;

  initial begin : rsp_monitor
    logic [34:0] exp;
    int          lat;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.rsp_ready = 1'b0; hold_cnt = 0; rsp_seen = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0;
      end else begin
        if (bus.rsp_valid) begin
          check("cmd_ready_low_in_rsp", 64'(bus.cmd_ready), 64'd0);
          if (prev_rv && !prev_rr)
            check("rsp_stable", 64'({bus.rsp_write, bus.rsp_resp, bus.rsp_rdata}), 64'(prev_rsp));
          if (!rsp_seen) begin rsp_seen = 1'b1; first_cyc = cyc; end
          if (hold_cnt >= rsp_hold) begin
            bus.rsp_ready = 1'b1;
            hold_cnt = 0;
            rsp_seen = 1'b0;
            if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
            else begin
              exp = exp_q.pop_front();
              lat = exp_lat_q.pop_front();
              check("rsp_write", 64'(bus.rsp_write), 64'(exp[34]));
              check("rsp_resp", 64'(bus.rsp_resp), 64'(exp[33:32]));
              check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp[31:0]));
              // latency counts the accept cycle and the first rsp_valid cycle
              if (lat != 0) check("latency", 64'(first_cyc - acc_cyc + 1), 64'(lat));
            end
          end else begin
            bus.rsp_ready = 1'b0;
            hold_cnt++;
          end
        end else begin
          bus.rsp_ready = 1'b0;
        end
        prev_rv = bus.rsp_valid;
        prev_rr = bus.rsp_ready;
        prev_rsp = {bus.rsp_write, bus.rsp_resp, bus.rsp_rdata};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wr, input logic [13:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int lat);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    logic        accepted = 1'b0;
    if (addr[1:0] != 2'b00) begin
      exp_d = '0; exp_r = RESP_SLVERR;
    end else if (wr) begin
      exp_d = '0; exp_r = sl_resp;
      exp_aw_q.push_back(addr);
      exp_w_q.push_back({strb, data});
      ref_write(addr, data, strb);
      n_b_exp++;
    end else begin
      exp_d = ref_read(addr); exp_r = sl_resp;
      exp_ar_q.push_back(addr);
    end
    exp_q.push_back({wr, exp_r, exp_d});
    exp_lat_q.push_back(lat);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_wdata = data; bus.cmd_wstrb = strb;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.cmd_ready) begin accepted = 1'b1; acc_cyc = cyc; break; end
      @(negedge clk);
    end
    if (accepted) begin
      @(posedge clk);
      #1;
    end else check("cmd_accept_timeout", 64'd0, 64'd1);
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
  endtask

  task automatic wait_done();
    logic done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) begin
      check("rsp_timeout", 64'd0, 64'd1);
      exp_q.delete(); exp_lat_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valids_readies"}, 64'({bus.cmd_ready, bus.rsp_valid, bus.m_axi_awvalid,
          bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready, bus.m_axi_rready}), 64'd0);
    check({tag, "_addrs"}, 64'({bus.m_axi_awaddr, bus.m_axi_araddr}), 64'd0);
    check({tag, "_wdata"}, 64'(bus.m_axi_wdata), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    check({tag, "_resp_write_strb"}, 64'({bus.rsp_resp, bus.rsp_write, bus.m_axi_wstrb}), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic        wr, found;
    logic [13:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lat;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.rsp_ready = 1'b0;
    slave_clear();
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // zero-wait write and readback
    issue(1'b1, 14'h0010, 32'hDEADBEEF, 4'hF, 4); wait_done();
    issue(1'b0, 14'h0010, 32'h0, 4'h0, 4); wait_done();

    // AW accepted three cycles after W
    aw_lat = 3;
    issue(1'b1, 14'h0020, 32'hCAFEF00D, 4'hF, 0); wait_done();
    aw_lat = 0;

    // top-of-range read with delayed R and a slow response consumer
    issue(1'b1, 14'h3FFC, 32'h12345678, 4'hF, 4); wait_done();
    r_lat = 2; rsp_hold = 5;
    issue(1'b0, 14'h3FFC, 32'h0, 4'h0, 0); wait_done();
    r_lat = 0; rsp_hold = 0;

    // misaligned accesses never reach the bus
    axi_valid_seen = 1'b0;
    issue(1'b1, 14'h0002, 32'h11111111, 4'hF, 0); wait_done();
    issue(1'b0, 14'h0003, 32'h0, 4'h0, 0); wait_done();
    check("misaligned_no_axi", 64'(axi_valid_seen), 64'd0);

    // error codes pass through
    sl_resp = RESP_DECERR;
    issue(1'b0, 14'h0010, 32'h0, 4'h0, 4); wait_done();
    sl_resp = RESP_SLVERR;
    issue(1'b1, 14'h0030, 32'hA5A5A5A5, 4'h5, 4); wait_done();
    sl_resp = RESP_OKAY;

    // reset while waiting for B
    b_lat = 8;
    issue(1'b1, 14'h0040, 32'h0BADF00D, 4'h3, 0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_state == ST_WR_B) begin found = 1'b1; break; end
    end
    check("reached_wr_b", 64'(found), 64'd1);
    #2;
    rst_n = 1'b0;
    slave_clear();
    #1;
    check_outputs_zero("midreset");
    exp_q.delete(); exp_lat_q.delete();
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    n_b_exp--;
    b_lat = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 14'h0040, 32'h0, 4'h0, 4); wait_done();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 14'(14'h0100 + ($urandom_range(0, 15) << 2));
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      b_lat = $urandom_range(0, 3); rsp_hold = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        2: sl_resp = RESP_SLVERR;
        3: sl_resp = RESP_DECERR;
        default: sl_resp = RESP_OKAY;
      endcase
      lat = (addr[1:0] == 2'b00 && aw_lat == 0 && w_lat == 0 && ar_lat == 0 &&
             r_lat == 0 && b_lat == 0) ? 4 : 0;
      issue(wr, addr, data, strb, lat);
      wait_done();
    end

    repeat (4) @(negedge clk);
    check("b_handshake_count", 64'(n_b_seen), 64'(n_b_exp));
    check("leftover_expectations",
          64'(exp_q.size() + exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_axi_lite_host_master.md
Name: mips_axi_lite_host_master

Overview:
- AXI4-Lite initiator that drives the 14-bit MMIO slave port of the MIPS CPU top (AR/AW/W/B/R channels) from a simple single-outstanding request/response command interface.
- Used by the host-side loader/debug path to:
  - write instruction/data memory,
  - poll CPU status registers,
  - release CPU reset via MMIO.
- Exactly one transaction is in flight at any time. No bursts, no IDs.

Parameters:
- ADDR_W, 14, AXI address width; matches the CPU slave port.
- DATA_W, 32, data width; fixed at 32.

Ports:
- mips_cpu_clk  in  1  single clock for all logic
- mips_cpu_reset  in  1  asynchronous active-low reset (0 = reset)
- cmd_valid  in  1  request valid
- cmd_ready  out  1  request accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_write  out  1  echoes cmd_write of the completed request
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  AXI response code
- m_axi_araddr  out  ADDR_W
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_awaddr  out  ADDR_W
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  DATA_W
- m_axi_wstrb  out  4
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- m_axi_rdata  in  DATA_W
- m_axi_rresp  in  2
- m_axi_rvalid  in  1
- m_axi_rready  out  1

Behaviour:
- Reset (mips_cpu_reset = 0, asynchronous):
  - State = IDLE.
  - All *valid and *ready outputs = 0; all address, data and resp outputs = 0.
  - Reset takes effect immediately even mid-transaction; any in-flight AXI transfer is abandoned.
- FSM states: IDLE, WR, WR_B, RD_A, RD_R, RSP.
- IDLE:
  - cmd_ready = 1 only in this state.
  - On accept, cmd fields are registered.
  - If cmd_addr[1:0] != 0: go to RSP with rsp_resp = 2'b10 and rsp_rdata = 0. No AXI activity.
  - Else a write goes to WR; a read goes to RD_A.
  - AXI valids assert on the cycle after accept.
- WR:
  - awvalid and wvalid assert together.
  - Each drops independently on the cycle after its own handshake (valid & ready sampled high).
  - Both valids hold their values stably until their handshake; no valid is deasserted early.
  - Once both handshakes are done (same or different cycles), go to WR_B.
- WR_B:
  - bready = 1.
  - On bvalid: capture bresp, set rdata = 0, go to RSP.
- RD_A:
  - arvalid = 1 until arready, then go to RD_R.
- RD_R:
  - rready = 1.
  - On rvalid: capture rdata and rresp, go to RSP.
- RSP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready, then go to IDLE.
  - cmd_ready stays 0 in RSP, so back-to-back commands are separated by at least one IDLE cycle.
- Latency, zero-wait slave: 4 cycles for a write and 4 cycles for a read, cmd accept to rsp_valid.
- rsp_resp passes the AXI code through (OKAY 00 / SLVERR 10 / DECERR 11). No retry on error.
- Inputs on channels not currently active are ignored (e.g. bvalid while in RD_R).

Decomposition:
- Shared package `mips_axi_pkg`:
  - FSM state encoding,
  - AXI resp constants (RESP_OKAY, RESP_SLVERR, RESP_DECERR),
  - ADDR_W default.
- No sub-module required.
- The AW/W dual-handshake tracking (two "done" flags) stays inline.

Test Plan:
- Write, zero-wait slave: addr 0x0010, data 0xDEADBEEF, strb 0xF → single AW and W beat with those values, bready high, rsp_valid after 4 cycles with resp 00.
- Write with skewed ready: awready 3 cycles late, wready immediate → wvalid drops after its handshake, awvalid held with a stable address, exactly one B accepted, resp 00.
- Read with backpressure: addr 0x3FFC, slave returns 0x12345678 with 2-cycle rvalid delay, bench holds rsp_ready low for 5 cycles → rsp_rdata = 0x12345678 held stable, cmd_ready stays 0 until consumed.
- Misaligned: addr 0x0002 → no AXI valid ever asserted, rsp_resp = 10, rsp_rdata = 0.
- Error passthrough: read returns rresp 11 → rsp_resp = 11.
- Reset mid-transaction: assert mips_cpu_reset = 0 while in WR_B → all outputs 0 asynchronously; after release, a new read completes normally.
